// File: rtl/sisc_pkg.sv
// Shared SISC definitions: bus width defaults, memory FSM states and
// requester port selection used by the memory responder, datapath and ctrl.
package sisc_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } mem_state_e;

  typedef enum logic {
    DATA  = 1'b0,
    INSTR = 1'b1
  } mem_port_e;

endpackage

// File: rtl/sisc_sram.sv
// Single-port synchronous word array; reads are registered and only a read
// access updates rdata. Contents are not reset.
module sisc_sram #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Array write or registered read on an enabled access edge
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/sisc_mem_ctrl.sv
// SISC memory responder: arbitrates fetch and data requests onto one
// single-ported array with WAIT programmable access cycles and req/ack handshakes.
module sisc_mem_ctrl
  import sisc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              busy
);

  localparam int              SRAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_CNT  = 4'(WAIT);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_e        state_q, state_d;
  mem_port_e         port_q, port_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic              err_q, err_d, busy_q, busy_d;
  logic [DATA_W-1:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;

  logic              oor_s, access_s;
  logic [DATA_W-1:0] sram_rdata_s, rd_result_s;

  assign oor_s       = {1'b0, addr_q} >= DEPTH_LIM;
  assign access_s    = (state_q == ACCESS) && (cnt_q == 4'd0);
  // err_q is high exactly in an out-of-range ACK cycle, forcing a zero result
  assign rd_result_s = err_q ? '0 : sram_rdata_s;

  sisc_sram #(
    .AW   (SRAM_AW),
    .DW   (DATA_W),
    .DEPTH(DEPTH)
  ) u_sram (
    .clk  (clk),
    .en   (access_s && !oor_s),
    .we   (we_q),
    .addr (addr_q[SRAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(sram_rdata_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_req || i_req) state_d = ACCESS; else state_d = IDLE;
      ACCESS:  if (cnt_q == 4'd0) state_d = ACK; else state_d = ACCESS;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and wait counter; data port wins a collision
  always_comb begin
    port_d  = port_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          port_d  = DATA;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          cnt_d   = WAIT_CNT;
        end else if (i_req) begin
          port_d = INSTR;
          addr_d = i_addr;
          we_d   = 1'b0;
          cnt_d  = WAIT_CNT;
        end else begin
          cnt_d = 4'd0;
        end
      end
      ACCESS:  if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1; else cnt_d = 4'd0;
      default: cnt_d = 4'd0;
    endcase
  end

  // FSM outputs: ack steering, error flag, busy and held read results
  always_comb begin
    i_ack_d   = (state_d == ACK) && (port_q == INSTR);
    d_ack_d   = (state_d == ACK) && (port_q == DATA);
    err_d     = access_s && oor_s;
    busy_d    = (state_d != IDLE);
    i_data_d  = i_ack_q ? rd_result_s : i_data_q;
    d_rdata_d = (d_ack_q && !we_q) ? rd_result_s : d_rdata_q;
  end

  // Capture, counter and output registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      port_q    <= DATA;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      port_q    <= port_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // The array result is live during the ack cycle, then held in the output register
  assign i_data  = i_ack_q ? rd_result_s : i_data_q;
  assign d_rdata = (d_ack_q && !we_q) ? rd_result_s : d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sisc_mem_ctrl.sv
// Directed bench for sisc_mem_ctrl: instance 0 runs with WAIT=2, instance 1
// with WAIT=0; both share clock and reset.
module tb_sisc_mem_ctrl;

  logic              clk = 1'b0;
  logic              rst_f;
  logic [1:0]        i_req, d_req, d_we;
  logic [1:0][15:0]  i_addr, d_addr;
  logic [1:0][31:0]  d_wdata;
  wire  [1:0][31:0]  i_data, d_rdata;
  wire  [1:0]        i_ack, d_ack, err, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sisc_mem_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT(2)) u_dut_w2 (
    .clk(clk), .rst_f(rst_f),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_data(i_data[0]), .i_ack(i_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .err(err[0]), .busy(busy[0])
  );

  sisc_mem_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT(0)) u_dut_w0 (
    .clk(clk), .rst_f(rst_f),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_data(i_data[1]), .i_ack(i_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One data transaction on instance k; lat counts edges from the drive point to the ack
  task automatic data_xfer(input int k, input logic we, input logic [15:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    @(posedge clk); #1;
    d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    lat = 0; rd = '0; er = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (d_ack[k]) begin
        lat = e; rd = d_rdata[k]; er = err[k];
        break;
      end
    end
    d_req[k] = 1'b0;
    if (lat == 0) check_eq("data_ack_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd, pre [4];
  logic        er;
  int          lat, lat_k [2], d_edge, i_edge, n, prev, idle_cnt;

  initial begin
    pre = '{32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444, 32'hFEED_C0DE};
    rst_f = 1'b0;
    i_req = '1; d_req = '1; d_we = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset held with requests pending: everything quiet
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("rst_flags", {24'd0, i_ack, d_ack, err, busy}, 32'd0);
      check_eq("rst_data", i_data[0] | d_rdata[0] | i_data[1] | d_rdata[1], 32'd0);
    end
    rst_f = 1'b1; i_req = '0;
    lat_k[0] = -1; lat_k[1] = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (d_ack[k] && lat_k[k] < 0) begin
          lat_k[k] = e; d_req[k] = 1'b0;
        end
      end
    end
    check_eq("rst_first_lat_w2", lat_k[0], 32'd4);
    check_eq("rst_first_lat_w0", lat_k[1], 32'd2);

    // Store then load at WAIT=2
    data_xfer(0, 1'b1, 16'h0010, 32'h1234_5678, rd, er, lat);
    check_eq("store_lat", lat, 32'd4);
    check_eq("store_err", {31'd0, er}, 32'd0);
    data_xfer(0, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    check_eq("load_lat", lat, 32'd4);
    check_eq("load_data", rd, 32'h1234_5678);
    @(posedge clk); #1;
    check_eq("ack_one_cycle", {31'd0, d_ack[0]}, 32'd0);
    @(posedge clk); #1;
    check_eq("load_held", d_rdata[0], 32'h1234_5678);

    // Collision: data wins, fetch follows WAIT+3 cycles later with new data
    @(posedge clk); #1;
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0010; d_wdata[0] = 32'hCAFE_F00D;
    d_edge = 0; i_edge = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 5) check_eq("coll_idle_busy", {31'd0, busy[0]}, 32'd0);
      if (d_ack[0] && i_ack[0]) check_eq("coll_both_ack", 32'd1, 32'd0);
      if (d_ack[0]) begin d_edge = e; d_req[0] = 1'b0; end
      if (i_ack[0]) begin
        i_edge = e; i_req[0] = 1'b0;
        check_eq("coll_i_data", i_data[0], 32'hCAFE_F00D);
        break;
      end
    end
    check_eq("coll_d_edge", d_edge, 32'd4);
    check_eq("coll_i_edge", i_edge, 32'd9);

    // Back-to-back fetches at WAIT=0 after preloading
    for (int i = 0; i < 4; i++) begin
      data_xfer(1, 1'b1, 16'(i), pre[i], rd, er, lat);
      if (i == 0) check_eq("w0_store_lat", lat, 32'd2);
    end
    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 16'h0000;
    n = 0; prev = 0; idle_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (n > 0 && n < 4 && !busy[1]) idle_cnt++;
      if (i_ack[1]) begin
        check_eq("b2b_data", i_data[1], pre[n]);
        check_eq("b2b_gap", e - prev, (n == 0) ? 32'd2 : 32'd3);
        prev = e; n++;
        if (n == 4) begin
          i_req[1] = 1'b0;
          break;
        end
        i_addr[1] = 16'(n);
      end
    end
    check_eq("b2b_count", n, 32'd4);
    check_eq("b2b_idle_cycles", idle_cnt, 32'd3);

    // Out-of-range accesses at DEPTH=256
    data_xfer(0, 1'b1, 16'h0000, 32'h5A5A_5A5A, rd, er, lat);
    data_xfer(0, 1'b0, 16'h0100, 32'h0, rd, er, lat);
    check_eq("oor_load_err", {31'd0, er}, 32'd1);
    check_eq("oor_load_data", rd, 32'd0);
    @(posedge clk); #1;
    check_eq("oor_err_one_cycle", {31'd0, err[0]}, 32'd0);
    data_xfer(0, 1'b1, 16'h0100, 32'hFFFF_FFFF, rd, er, lat);
    check_eq("oor_store_err", {31'd0, er}, 32'd1);
    data_xfer(0, 1'b0, 16'h0000, 32'h0, rd, er, lat);
    check_eq("oor_no_alias", rd, 32'h5A5A_5A5A);
    check_eq("inrange_err", {31'd0, er}, 32'd0);

    // Reset during ACCESS discards the pending store
    data_xfer(0, 1'b1, 16'h0005, 32'hDEAD_BEEF, rd, er, lat);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0005; d_wdata[0] = 32'h0;
    @(posedge clk); #1;
    check_eq("mid_busy", {31'd0, busy[0]}, 32'd1);
    rst_f = 1'b0; d_req[0] = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    rst_f = 1'b1;
    data_xfer(0, 1'b0, 16'h0005, 32'h0, rd, er, lat);
    check_eq("rst_store_discarded", rd, 32'hDEAD_BEEF);

    // Reset in the ack cycle drops ack at once
    rst_f = 1'b0;
    #1;
    check_eq("ack_async_drop", {30'd0, d_ack[0], d_rdata[0] != 32'd0}, 32'd0);
    @(posedge clk); #1;
    rst_f = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
